d_sramlike_axi_bridge: RTL and testbench

- Converts the data cache's SRAM-like miss/write-back port into single-beat AXI read and write transactions; sits directly downstream of the data cache, between it and the AXI crossbar.
- One transaction outstanding at a time. Bursts, IDs and interleaving are not supported.
- Error reporting is optional and compile-time selected (see Configuration).

---
 rtl/d_sramlike_axi_bridge.sv | 178 +++++++++++++++++
 tb/tb_d_sramlike_axi_bridge.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_sramlike_axi_bridge.sv
// SRAM-like data-cache port to single-beat AXI bridge, one transaction in flight.
// Optional sticky AXI error flag enabled by defining DBRIDGE_ERR_EN.
module d_sramlike_axi_bridge #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // Cache side
  input  logic                  cache_data_req,
  input  logic                  cache_data_wr,
  input  logic [1:0]            cache_data_size,
  input  logic [ADDR_WIDTH-1:0] cache_data_addr,
  input  logic [31:0]           cache_data_wdata,
  output logic [31:0]           cache_data_rdata,
  output logic                  cache_data_addr_ok,
  output logic                  cache_data_data_ok,
  // AXI read address
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arsize,
  output logic                  arvalid,
  input  logic                  arready,
  // AXI read data
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  // AXI write address
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awsize,
  output logic                  awvalid,
  input  logic                  awready,
  // AXI write data
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  // AXI write response
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  bus_err
);

  typedef enum logic [2:0] {
    StIdle,
    StRaddr,
    StRdata,
    StWaddr,
    StWresp
  } state_e;

  state_e                  state_q;
  logic [1:0]              req_size_q;
  logic [ADDR_WIDTH-1:0]   req_addr_q;
  logic [31:0]             req_wdata_q;
  logic                    arvalid_q;
  logic                    rready_q;
  logic                    awvalid_q;
  logic                    wvalid_q;
  logic                    bready_q;

  logic                    r_done;
  logic                    b_done;
  logic                    aw_fin;
  logic                    w_fin;

  assign r_done = (state_q == StRdata) && rvalid && rready_q;
  assign b_done = (state_q == StWresp) && bvalid && bready_q;

  // A channel is finished once its valid has dropped or is handshaking this cycle.
  assign aw_fin = !awvalid_q || awready;
  assign w_fin  = !wvalid_q || wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      req_size_q  <= 2'b00;
      req_addr_q  <= '0;
      req_wdata_q <= 32'h0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cache_data_req) begin
            req_size_q  <= cache_data_size;
            req_addr_q  <= cache_data_addr;
            req_wdata_q <= cache_data_wdata;
            if (cache_data_wr) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= StWaddr;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= StRaddr;
            end
          end
        end
        StRaddr: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdata;
          end
        end
        StRdata: begin
          if (rvalid) begin
            rready_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        StWaddr: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state_q  <= StWresp;
          end
        end
        StWresp: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Byte lanes follow the low address bits of the latched request.
  always_comb begin
    wstrb = 4'b1111;
    case (req_size_q)
      2'd0:    wstrb = 4'b0001 << req_addr_q[1:0];
      2'd1:    wstrb = req_addr_q[1] ? 4'b1100 : 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end

  assign cache_data_addr_ok = !rst && (state_q == StIdle) && cache_data_req;
  assign cache_data_data_ok = r_done || b_done;
  assign cache_data_rdata   = r_done ? rdata : 32'h0;

  assign araddr  = req_addr_q;
  assign arsize  = {1'b0, req_size_q};
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign awaddr  = req_addr_q;
  assign awsize  = {1'b0, req_size_q};
  assign awvalid = awvalid_q;
  assign wdata   = req_wdata_q;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

`ifdef DBRIDGE_ERR_EN
  logic bus_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err_q <= 1'b0;
    end else if ((r_done && (rresp != 2'b00)) || (b_done && (bresp != 2'b00))) begin
      bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  logic unused_resp;

  assign unused_resp = ^{rresp, bresp};
  assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_d_sramlike_axi_bridge.sv
// Bench for d_sramlike_axi_bridge: vector table driven through an AXI slave model,
// completions checked against a scoreboard queue, plus reset/abort sequences.
module tb_d_sramlike_axi_bridge;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int MaxCyc = 40;

  logic                  clk;
  logic                  rst;
  logic                  cache_data_req;
  logic                  cache_data_wr;
  logic [1:0]            cache_data_size;
  logic [ADDR_WIDTH-1:0] cache_data_addr;
  logic [31:0]           cache_data_wdata;
  logic [31:0]           cache_data_rdata;
  logic                  cache_data_addr_ok;
  logic                  cache_data_data_ok;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arsize;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awsize;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic                  bus_err;

  d_sramlike_axi_bridge #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .cache_data_req     (cache_data_req),
    .cache_data_wr      (cache_data_wr),
    .cache_data_size    (cache_data_size),
    .cache_data_addr    (cache_data_addr),
    .cache_data_wdata   (cache_data_wdata),
    .cache_data_rdata   (cache_data_rdata),
    .cache_data_addr_ok (cache_data_addr_ok),
    .cache_data_data_ok (cache_data_data_ok),
    .araddr             (araddr),
    .arsize             (arsize),
    .arvalid            (arvalid),
    .arready            (arready),
    .rdata              (rdata),
    .rresp              (rresp),
    .rvalid             (rvalid),
    .rready             (rready),
    .awaddr             (awaddr),
    .awsize             (awsize),
    .awvalid            (awvalid),
    .awready            (awready),
    .wdata              (wdata),
    .wstrb              (wstrb),
    .wvalid             (wvalid),
    .wready             (wready),
    .bresp              (bresp),
    .bvalid             (bvalid),
    .bready             (bready),
    .bus_err            (bus_err)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          a_dly;   // cycles before arready/awready
    int          w_dly;   // cycles before wready
    int          r_dly;   // cycles before rvalid/bvalid
    logic [31:0] rdata;
    logic [1:0]  resp;
    bit          hold;    // keep req asserted until completion
    logic [3:0]  exp_strb;
    logic [2:0]  exp_axsize;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
  } sb_t;

  vec_t vecs[8];
  sb_t  sb_q[$];
  int   n_checks;
  int   n_errors;
  logic exp_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Completion monitor: each data_ok retires the oldest accepted request.
  always @(negedge clk) begin
    if (!rst && cache_data_data_ok) begin
      if (sb_q.size() == 0) begin
        chk("sb_spurious_data_ok", 1'b1, 1'b0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("sb_kind", bready, e.wr);
        if (!e.wr) chk("sb_rdata", cache_data_rdata, e.rdata);
      end
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    bit aw_done;
    bit w_done;
    bit done;
    bit vld;
    aw_done = 1'b0;
    w_done  = 1'b0;
    done    = 1'b0;
    @(posedge clk); #1;
    rvalid = 1'b0; bvalid = 1'b0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    cache_data_req   = 1'b1;
    cache_data_wr    = v.wr;
    cache_data_size  = v.size;
    cache_data_addr  = v.addr;
    cache_data_wdata = v.wdata;
    @(negedge clk);
    chk({tag, ".addr_ok"}, cache_data_addr_ok, 1'b1);
    chk({tag, ".bus_err"}, bus_err, exp_err);
    sb_q.push_back('{wr: v.wr, rdata: v.rdata});

    for (int k = 0; k < MaxCyc && !done; k++) begin
      @(posedge clk); #1;
      if (!v.hold) begin
        cache_data_req   = 1'b0;
        cache_data_addr  = ~v.addr;
        cache_data_wdata = ~v.wdata;
      end
      if (v.wr) begin
        awready = (k >= v.a_dly);
        wready  = (k >= v.w_dly);
      end else begin
        arready = (k >= v.a_dly);
      end
      @(negedge clk);
      chk({tag, ".addr_ok_busy"}, cache_data_addr_ok, 1'b0);
      chk({tag, ".data_ok_early"}, cache_data_data_ok, 1'b0);
      if (!v.wr) begin
        chk({tag, ".arvalid"}, arvalid, 1'b1);
        chk({tag, ".araddr"}, araddr, v.addr);
        chk({tag, ".arsize"}, arsize, v.exp_axsize);
        done = arvalid && arready;
      end else begin
        chk({tag, ".awvalid"}, awvalid, !aw_done);
        chk({tag, ".wvalid"}, wvalid, !w_done);
        if (!aw_done) begin
          chk({tag, ".awaddr"}, awaddr, v.addr);
          chk({tag, ".awsize"}, awsize, v.exp_axsize);
        end
        if (!w_done) begin
          chk({tag, ".wdata"}, wdata, v.wdata);
          chk({tag, ".wstrb"}, wstrb, v.exp_strb);
        end
        if (awvalid && awready) aw_done = 1'b1;
        if (wvalid && wready) w_done = 1'b1;
        done = aw_done && w_done;
      end
    end
    chk({tag, ".addr_phase_done"}, done, 1'b1);

    done = 1'b0;
    for (int k = 0; k < MaxCyc && !done; k++) begin
      @(posedge clk); #1;
      arready = 1'b0; awready = 1'b0; wready = 1'b0;
      vld = (k >= v.r_dly);
      if (v.wr) begin
        bvalid = vld;
        bresp  = v.resp;
      end else begin
        rvalid = vld;
        rdata  = v.rdata;
        rresp  = v.resp;
      end
      @(negedge clk);
      chk({tag, ".resp_ready"}, v.wr ? bready : rready, 1'b1);
      chk({tag, ".valids_low"}, {arvalid, awvalid, wvalid}, 3'b000);
      chk({tag, ".data_ok"}, cache_data_data_ok, vld);
      chk({tag, ".addr_ok_resp"}, cache_data_addr_ok, 1'b0);
      done = vld;
    end
    chk({tag, ".resp_done"}, done, 1'b1);
`ifdef DBRIDGE_ERR_EN
    if (v.resp != 2'b00) exp_err = 1'b1;
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_err  = 1'b0;
    //            wr    size  addr          wdata         a  w  r  rdata         resp  hold strb     axsize
    vecs[0] = '{1'b0, 2'd2, 32'h0000_1004, 32'h0,        0, 0, 0, 32'hDEAD_BEEF, 2'b00, 0, 4'b0000, 3'd2};
    vecs[1] = '{1'b1, 2'd0, 32'h0000_2003, 32'hAB00_0000, 0, 0, 0, 32'h0,        2'b00, 0, 4'b1000, 3'd0};
    vecs[2] = '{1'b1, 2'd1, 32'h0000_3002, 32'h1234_0000, 0, 3, 0, 32'h0,        2'b00, 0, 4'b1100, 3'd1};
    vecs[3] = '{1'b0, 2'd0, 32'h0000_4001, 32'h0,        5, 0, 2, 32'h0BAD_F00D, 2'b00, 1, 4'b0000, 3'd0};
    vecs[4] = '{1'b1, 2'd2, 32'h0000_5000, 32'hCAFE_F00D, 2, 0, 1, 32'h0,        2'b10, 0, 4'b1111, 3'd2};
    vecs[5] = '{1'b0, 2'd1, 32'h0000_6002, 32'h0,        1, 0, 0, 32'h55AA_33CC, 2'b00, 0, 4'b0000, 3'd1};
    vecs[6] = '{1'b1, 2'd0, 32'h0000_7001, 32'h0000_5A00, 0, 0, 0, 32'h0,        2'b00, 0, 4'b0010, 3'd0};
    vecs[7] = '{1'b1, 2'd1, 32'h0000_8000, 32'h0000_BEEF, 1, 1, 0, 32'h0,        2'b00, 0, 4'b0011, 3'd1};

    rst = 1'b1;
    cache_data_req = 1'b1;  // addr_ok must stay low while reset is held
    cache_data_wr = 1'b0; cache_data_size = 2'd0;
    cache_data_addr = '0; cache_data_wdata = 32'h0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rvalid = 1'b0; bvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; bresp = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("reset.ctrl_outs",
        {cache_data_addr_ok, cache_data_data_ok, arvalid, awvalid, wvalid, rready, bready, bus_err},
        8'h00);
    chk("reset.rdata", cache_data_rdata, 32'h0);
    cache_data_req = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort a read in RDATA with reset, rvalid arriving in the same instant.
    @(posedge clk); #1;
    cache_data_req = 1'b1; cache_data_wr = 1'b0; cache_data_size = 2'd2;
    cache_data_addr = 32'h0000_9008;
    @(negedge clk);
    chk("abort.addr_ok", cache_data_addr_ok, 1'b1);
    sb_q.push_back('{wr: 1'b0, rdata: 32'h0});
    @(posedge clk); #1;
    cache_data_req = 1'b0; arready = 1'b1;
    @(negedge clk);
    chk("abort.arvalid", arvalid, 1'b1);
    @(posedge clk); #1;
    arready = 1'b0;
    @(negedge clk);
    chk("abort.in_rdata", rready, 1'b1);
    #1;
    rvalid = 1'b1; rdata = 32'h1357_9BDF; rst = 1'b1;
    #1;
    chk("abort.ctrl_outs",
        {cache_data_addr_ok, cache_data_data_ok, arvalid, awvalid, wvalid, rready, bready, bus_err},
        8'h00);
    chk("abort.rdata", cache_data_rdata, 32'h0);
    sb_q.delete();
    exp_err = 1'b0;
    @(negedge clk);
    rst = 1'b0; rvalid = 1'b0;
    run_vec('{1'b0, 2'd2, 32'h0000_A000, 32'h0, 0, 0, 0, 32'h2468_ACE0, 2'b00, 0, 4'b0000, 3'd2},
            "post_reset");

    @(posedge clk); #1;
    rvalid = 1'b0; bvalid = 1'b0;
    @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    chk("final.bus_err", bus_err, exp_err);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
